mdr_mem_if: RTL and testbench
=============================

Name: mdr_mem_if

Overview:
Next-generation memory data register: a parametrised-width MDR with an explicit req/ack memory handshake and byte-lane addressing.
- Reads: byte/half/full-width loads with zero or sign extension.
- Writes: stores with lane-shifted data and byte enables.
- Sits between the CPU internal bus and the memory port, sequenced by control-unit start pulses.
- Replaces tri-state bus driving with bus_out plus bus_oe.

Parameters:
DATA_WIDTH, 32, register/bus/memory data width; multiple of 8, minimum 16.
TIMEOUT_CYCLES, 255, wait-cycle limit before abort; used only with MDR_TIMEOUT_EN.

Ports:
clock  in  1  system clock, all state on rising edge.
clear  in  1  synchronous active-low reset.
bus_in  in  DATA_WIDTH  data from internal bus.
mdr_in  in  1  load bus_in into MDR (honoured in IDLE only).
mdr_out  in  1  request to drive the bus.
bus_out  out  DATA_WIDTH  MDR contents (always mdr_q).
bus_oe  out  1  bus drive enable; equals mdr_out.
rd_start  in  1  start memory read (1-cycle pulse).
wr_start  in  1  start memory write (1-cycle pulse).
size  in  2  00 byte, 01 half, 1x full width.
sign_ext  in  1  reads: 1 = sign-extend, 0 = zero-extend.
addr_lo  in  clog2(DATA_WIDTH/8)  byte offset within the word.
mem_rd  out  1  read strobe.
mem_wr  out  1  write strobe.
mem_be  out  DATA_WIDTH/8  byte enables.
mem_wdata  out  DATA_WIDTH  write data.
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1.
mem_ack  in  1  memory completion.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle error pulse.

Behaviour:
- Reset (clear=0 at an edge): mdr_q=0, state IDLE; mem_rd=mem_wr=0, mem_be=0, mem_wdata=0; done=err=0. Takes effect from any state.
- Reset mid-transaction drops strobes at the same edge; no done or err is produced.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, ERR.
- IDLE edge priority: rd_start > wr_start > mdr_in.
  - mdr_in alone: mdr_q <= bus_in.
  - rd_start/wr_start, or mdr_in while not IDLE: ignored.
- size/sign_ext/addr_lo are latched at the start edge and are don't-care afterwards.
- Misalignment: half with addr_lo[0]=1, or full width with addr_lo!=0.
  - Start goes to ERR instead of WAIT: err=1 for one cycle, then IDLE.
  - No strobe is issued; mdr_q is unchanged.
- RD_WAIT:
  - mem_rd=1 and mem_be = size mask << addr_lo, held stable until mem_ack is sampled 1.
  - At the ack edge: mdr_q <= extracted lane, extended to DATA_WIDTH; mem_rd=0; next state DONE.
- WR_WAIT:
  - mem_wr=1; mem_wdata = mdr_q low bytes shifted left by 8*addr_lo; mem_be as for reads.
  - At the ack edge: go to DONE; mdr_q unchanged.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- Minimum latency: start edge to done high is 2 cycles (ack in first wait cycle). Each wait cycle adds 1.
- mem_ack outside a WAIT state is ignored.
- mem_wdata/mem_be hold their last values in IDLE. Consumers qualify them with the strobes.

Optional Feature:
MDR_TIMEOUT_EN:
- Defined: an 8+ bit wait counter clears on WAIT entry and increments each WAIT cycle with ack=0.
  - When it reaches TIMEOUT_CYCLES, the strobe drops at that edge and the FSM goes to ERR (err pulse).
  - mdr_q is unchanged; a late ack is ignored.
- Undefined: WAIT states persist indefinitely; err arises only from misalignment.

Decomposition:
- Package mdr_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_FULL); state enum; be_mask(size) function; BE_WIDTH/OFS_WIDTH derivation.
- Sub-module mdr_lane_align (combinational): lane extraction plus sign/zero extension for reads, and data/byte-enable shifting for writes.
- mdr_mem_if holds the FSM, mdr_q, and the optional timeout counter.

Test Plan (DATA_WIDTH=32):
1. mdr_in=1, bus_in=0xDEADBEEF, then mdr_out=1 -> bus_out=0xDEADBEEF, bus_oe=1, busy=0.
2. Read byte, addr_lo=2, sign_ext=1, mem_rdata=0x12803456, ack after 3 wait cycles -> mem_be=4'b0100; mem_rd high exactly 4 cycles; mdr_q=0xFFFFFF80; done one cycle.
3. mdr_q=0x0000ABCD, write half, addr_lo=2, ack immediately -> mem_wdata=0xABCD0000, mem_be=4'b1100, mem_wr 1 cycle, done at start+2.
4. Read full width, addr_lo=1 -> err one cycle at start+1; mem_rd never asserts; mdr_q unchanged.
5. rd_start then clear=0 during RD_WAIT -> mem_rd=0 and busy=0 after that edge; done never pulses; mdr_q=0.
6. MDR_TIMEOUT_EN, TIMEOUT_CYCLES=4, read, no ack -> mem_rd drops after 4 wait cycles; err pulses; later ack ignored.

Source files
------------

// File: rtl/mdr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdr_pkg : shared types and helpers for the memory data register.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mdr_pkg;

  localparam int MAX_BE = 128;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_FULL = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  function automatic int ofs_width(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Both 2'b10 and 2'b11 select a full-width access.
  function automatic size_e decode_size(input logic [1:0] sz);
    if (sz[1]) return SZ_FULL;
    else if (sz[0]) return SZ_HALF;
    else return SZ_BYTE;
  endfunction

  function automatic logic [MAX_BE-1:0] be_mask(input size_e sz, input int bew);
    logic [MAX_BE-1:0] m;
    case (sz)
      SZ_BYTE: m = MAX_BE'(1);
      SZ_HALF: m = MAX_BE'(3);
      default: m = {MAX_BE{1'b1}} >> (MAX_BE - bew);
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdr_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdr_lane_align : read lane extraction/extension, write data/BE shifting. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int BE_W       = be_width(DATA_WIDTH),
  localparam int OFS_W      = ofs_width(DATA_WIDTH)
) (
  input  size_e                 size_i,
  input  logic                  sign_ext_i,
  input  logic [OFS_W-1:0]      addr_lo_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [BE_W-1:0]       be_o
);

  localparam logic [DATA_WIDTH-1:0] C_MASK8  = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] C_MASK16 = DATA_WIDTH'(16'hFFFF);

  logic [OFS_W+2:0]      w_shamt;
  logic [MAX_BE-1:0]     w_mask_full;
  logic [BE_W-1:0]       w_mask;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic [DATA_WIDTH-1:0] w_rd_sh;

  assign w_shamt     = {addr_lo_i, 3'b000};
  assign w_mask_full = be_mask(size_i, BE_W);
  assign w_mask      = w_mask_full[BE_W-1:0];
  assign be_o        = w_mask << addr_lo_i;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane_mask
    assign w_lane_mask[gi*8 +: 8] = {8{w_mask[gi]}};
  end

  // Only the low bytes of the MDR that the access covers reach the bus.
  assign wdata_o = (wdata_i & w_lane_mask) << w_shamt;
  assign w_rd_sh = rdata_i >> w_shamt;

  always_comb begin
    rdata_o = w_rd_sh;
    case (size_i)
      SZ_BYTE: rdata_o = (w_rd_sh & C_MASK8)
                       | ({DATA_WIDTH{sign_ext_i & w_rd_sh[7]}} & ~C_MASK8);
      SZ_HALF: rdata_o = (w_rd_sh & C_MASK16)
                       | ({DATA_WIDTH{sign_ext_i & w_rd_sh[15]}} & ~C_MASK16);
      default: rdata_o = w_rd_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdr_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdr_mem_if : memory data register with req/ack memory handshake.         |
// | Optional MDR_TIMEOUT_EN aborts WAIT states after TIMEOUT_CYCLES.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter int  DATA_WIDTH     = 32,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int BE_W           = be_width(DATA_WIDTH),
  localparam int OFS_W          = ofs_width(DATA_WIDTH)
) (
  input  logic                  clock_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] bus_in_i,
  input  logic                  mdr_in_i,
  input  logic                  mdr_out_i,
  output logic [DATA_WIDTH-1:0] bus_out_o,
  output logic                  bus_oe_o,
  input  logic                  rd_start_i,
  input  logic                  wr_start_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [OFS_W-1:0]      addr_lo_i,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [BE_W-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  size_e                 size_q, size_d;
  logic                  sign_q, sign_d;
  logic [OFS_W-1:0]      addr_q, addr_d;

  size_e                 w_sz_in;
  size_e                 w_al_size;
  logic [OFS_W-1:0]      w_al_addr;
  logic                  w_misalign;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_rd_ext;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_W-1:0]       w_be;

  assign w_sz_in    = decode_size(size_i);
  assign w_misalign = ((w_sz_in == SZ_HALF) && addr_lo_i[0])
                   || ((w_sz_in == SZ_FULL) && (addr_lo_i != '0));

  // Live controls set up the start edge; latched ones serve the WAIT states.
  assign w_al_size = (state_q == ST_IDLE) ? w_sz_in   : size_q;
  assign w_al_addr = (state_q == ST_IDLE) ? addr_lo_i : addr_q;

  mdr_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size_i     (w_al_size),
    .sign_ext_i (sign_q),
    .addr_lo_i  (w_al_addr),
    .rdata_i    (mem_rdata_i),
    .wdata_i    (mdr_q),
    .rdata_o    (w_rd_ext),
    .wdata_o    (w_wdata),
    .be_o       (w_be)
  );

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign w_timeout = !mem_ack_i && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) && !mem_ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!clear_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_start_i || wr_start_i) begin
          size_d = w_sz_in;
          sign_d = sign_ext_i;
          addr_d = addr_lo_i;
          if (w_misalign) begin
            state_d = ST_ERR;
          end else begin
            be_d = w_be;
            if (rd_start_i) begin
              state_d = ST_RD_WAIT;
            end else begin
              state_d = ST_WR_WAIT;
              wdata_d = w_wdata;
            end
          end
        end else if (mdr_in_i) begin
          mdr_d = bus_in_i;
        end
      end
      ST_RD_WAIT: begin
        if (mem_ack_i) begin
          mdr_d   = w_rd_ext;
          state_d = ST_DONE;
        end else if (w_timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ack_i)      state_d = ST_DONE;
        else if (w_timeout) state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!clear_i) begin
      state_q <= ST_IDLE;
      mdr_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
    end
  end

  assign bus_out_o   = mdr_q;
  assign bus_oe_o    = mdr_out_i;
  assign mem_rd_o    = (state_q == ST_RD_WAIT);
  assign mem_wr_o    = (state_q == ST_WR_WAIT);
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdr_mem_if : scoreboard bench for mdr_mem_if (DATA_WIDTH=32).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mdr_mem_if;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic        mdr_in, mdr_out;
  logic [31:0] bus_out;
  logic        bus_oe;
  logic        rd_start, wr_start;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  addr_lo;
  logic        mem_rd, mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, done, err;

  int nchecks = 0;
  int nerrors = 0;
  int cyc     = 0;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [31:0] mdr;
  } exp_t;

  exp_t exp_q[$];

  mdr_mem_if #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock_i     (clk),
    .clear_i     (clear),
    .bus_in_i    (bus_in),
    .mdr_in_i    (mdr_in),
    .mdr_out_i   (mdr_out),
    .bus_out_o   (bus_out),
    .bus_oe_o    (bus_oe),
    .rd_start_i  (rd_start),
    .wr_start_i  (wr_start),
    .size_i      (size),
    .sign_ext_i  (sign_ext),
    .addr_lo_i   (addr_lo),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (clear && (done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, err, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, err, done}, e.is_err ? 32'd2 : 32'd1);
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_mdr", bus_out, e.mdr);
        check("pulse_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // One transaction: start pulse, ack after nwait un-acked cycles, strobe/BE/data checks.
  task automatic xact(input bit is_rd, input logic [1:0] sz, input bit sx,
                      input logic [1:0] ofs, input logic [31:0] rdata, input int nwait,
                      input bit exp_err, input int off, input logic [31:0] exp_mdr,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input int exp_strb);
    exp_t e;
    int   strb;
    int   len;
    rd_start = is_rd;
    wr_start = !is_rd;
    size     = sz;
    sign_ext = sx;
    addr_lo  = ofs;
    e.is_err = exp_err;
    e.cyc    = cyc + 1 + off;
    e.mdr    = exp_mdr;
    exp_q.push_back(e);
    step();
    rd_start = 1'b0;
    wr_start = 1'b0;
    mdr_in   = 1'b0;
    size     = ~sz;
    sign_ext = !sx;
    addr_lo  = ~ofs;
    strb     = 0;
    len      = ((nwait > off) ? nwait : off) + 3;
    for (int i = 0; i < len; i++) begin
      mem_ack   = (i == nwait);
      mem_rdata = (i == nwait) ? rdata : ~rdata;
      if (is_rd ? mem_rd : mem_wr) begin
        strb++;
        check("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        if (!is_rd) check("mem_wdata", mem_wdata, exp_wd);
      end
      check("other_strobe", {31'd0, is_rd ? mem_wr : mem_rd}, 32'd0);
      step();
    end
    mem_ack = 1'b0;
    check("strobe_cycles", strb, exp_strb);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    mdr_in = 1'b1;
    bus_in = v;
    step();
    mdr_in = 1'b0;
    bus_in = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear     = 1'b0;
    bus_in    = 32'h0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    size      = 2'b00;
    sign_ext  = 1'b0;
    addr_lo   = 2'b00;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    repeat (3) step();
    clear = 1'b1;

    // Reset state
    check("rst_bus_out", bus_out, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);

    // Bus load and drive
    load_mdr(32'hDEADBEEF);
    mdr_out = 1'b1;
    #1;
    check("bus_out_load", bus_out, 32'hDEADBEEF);
    check("bus_oe", {31'd0, bus_oe}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
    mdr_out = 1'b0;
    #1;
    check("bus_oe_off", {31'd0, bus_oe}, 32'd0);

    // Signed byte read, lane 2, three wait cycles; concurrent mdr_in is ignored
    mdr_in = 1'b1;
    bus_in = 32'h11111111;
    xact(1, 2'b00, 1, 2'd2, 32'h12803456, 3, 0, 4, 32'hFFFFFF80, 4'b0100, 32'h0, 4);

    // Half store, lane 2, immediate ack
    load_mdr(32'h0000ABCD);
    xact(0, 2'b01, 0, 2'd2, 32'h0, 0, 0, 1, 32'h0000ABCD, 4'b1100, 32'hABCD0000, 1);

    // Misaligned full read: err only, no strobe, MDR untouched
    xact(1, 2'b10, 0, 2'd1, 32'h55555555, 0, 1, 0, 32'h0000ABCD, 4'b0000, 32'h0, 0);

    // More read lanes and extensions
    xact(1, 2'b01, 0, 2'd2, 32'h87654321, 1, 0, 2, 32'h00008765, 4'b1100, 32'h0, 2);
    xact(1, 2'b00, 0, 2'd3, 32'hF0000000, 0, 0, 1, 32'h000000F0, 4'b1000, 32'h0, 1);
    xact(1, 2'b01, 1, 2'd0, 32'h00009000, 0, 0, 1, 32'hFFFF9000, 4'b0011, 32'h0, 1);
    xact(1, 2'b11, 1, 2'd0, 32'hCAFEF00D, 2, 0, 3, 32'hCAFEF00D, 4'b1111, 32'h0, 3);

    // Store lanes and misaligned half store
    xact(0, 2'b00, 0, 2'd1, 32'h0, 1, 0, 2, 32'hCAFEF00D, 4'b0010, 32'h00000D00, 2);
    xact(0, 2'b10, 0, 2'd0, 32'h0, 0, 0, 1, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1);
    xact(0, 2'b01, 0, 2'd1, 32'h0, 0, 1, 0, 32'hCAFEF00D, 4'b0000, 32'h0, 0);

    // Reset in the middle of a read
    rd_start = 1'b1;
    size     = 2'b10;
    addr_lo  = 2'd0;
    step();
    rd_start = 1'b0;
    step();
    check("mid_mem_rd", {31'd0, mem_rd}, 32'd1);
    clear = 1'b0;
    step();
    check("rst_mid_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_mdr", bus_out, 32'h0);
    clear   = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("ack_in_idle_busy", {31'd0, busy}, 32'd0);
    repeat (3) step();

`ifdef MDR_TIMEOUT_EN
    // No ack within the limit: strobe drops after four wait cycles, late ack ignored
    xact(1, 2'b10, 0, 2'd0, 32'h5A5A5A5A, 6, 1, 4, 32'h0, 4'b1111, 32'h0, 4);
`endif

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
